// File: rtl/cache_mem_port_if.sv
// Bus bundle for cache_mem_port: CPU write-buffer path, cache line-fill
// handshake and the SDRAM request port.
interface cache_mem_port_if #(
  parameter int AW = 29
);
  logic          cpu_cs;
  logic [AW:1]   cpu_adr;
  logic [1:0]    cpu_bs;
  logic [15:0]   cpu_dat_w;
  logic          wb_en;
  logic          wb_ack;
  logic          mem_read_req;
  logic [63:0]   mem_dat_r;
  logic          mem_read_ack;
  logic          sd_req;
  logic          sd_we;
  logic [AW:1]   sd_addr;
  logic [1:0]    sd_be;
  logic [15:0]   sd_dout;
  logic [63:0]   sd_din;
  logic          sd_ack;

  // The port block itself.
  modport slave (
    input  cpu_cs, cpu_adr, cpu_bs, cpu_dat_w, wb_en, mem_read_req, sd_din, sd_ack,
    output wb_ack, mem_dat_r, mem_read_ack, sd_req, sd_we, sd_addr, sd_be, sd_dout
  );

  // The surrounding cache/CPU and SDRAM controller.
  modport master (
    output cpu_cs, cpu_adr, cpu_bs, cpu_dat_w, wb_en, mem_read_req, sd_din, sd_ack,
    input  wb_ack, mem_dat_r, mem_read_ack, sd_req, sd_we, sd_addr, sd_be, sd_dout
  );
endinterface

// File: rtl/cache_mem_port.sv
// Cache-to-SDRAM port: buffers CPU writes in a small FIFO and issues them
// ahead of any pending line fill, so a fill always observes earlier writes.
//
// state | meaning
// IDLE  | no SDRAM request outstanding; picks next write, else pending read
// WR    | write from FIFO head outstanding, waiting for sd_ack
// RD    | 4-word line fill outstanding, waiting for sd_ack
module cache_mem_port #(
  parameter int AW       = 29,
  parameter int WB_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  cache_mem_port_if.slave   bus
);

  localparam int PW = $clog2(WB_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = AW + 18;
  localparam logic [CW-1:0] FULL_CNT = CW'(WB_DEPTH);

  typedef enum logic [1:0] {IDLE, WR, RD} state_t;

  state_t          state_q, state_d;

  logic [EW-1:0]   fifo_mem [WB_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic            captured_q, captured_d;
  logic            wb_ack_q, wb_ack_d;
  logic            rd_pend_q, rd_pend_d;
  logic [AW:1]     rd_addr_q, rd_addr_d;

  logic            sd_req_q, sd_req_d;
  logic            sd_we_q, sd_we_d;
  logic [AW:1]     sd_addr_q, sd_addr_d;
  logic [1:0]      sd_be_q, sd_be_d;
  logic [15:0]     sd_dout_q, sd_dout_d;
  logic [63:0]     mem_dat_r_q, mem_dat_r_d;
  logic            mem_read_ack_q, mem_read_ack_d;

  logic            full, empty, push, pop, rd_done;
  logic [AW:1]     head_adr;
  logic [1:0]      head_bs;
  logic [15:0]     head_dat;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign push    = bus.wb_en & bus.cpu_cs & ~full & ~captured_q;
  assign pop     = (state_q == WR) & bus.sd_ack;
  assign rd_done = (state_q == RD) & bus.sd_ack;

  assign {head_adr, head_bs, head_dat} = fifo_mem[rd_ptr_q];

  // Write capture: one push per CPU access; ack held until the CPU lets go.
  always_comb begin
    captured_d = captured_q;
    wb_ack_d   = wb_ack_q;
    if (!bus.cpu_cs) begin
      captured_d = 1'b0;
      wb_ack_d   = 1'b0;
    end else if (push) begin
      captured_d = 1'b1;
      wb_ack_d   = 1'b1;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop cancel in the count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Line-fill request latch; a second request while one is pending is dropped.
  always_comb begin
    rd_pend_d = rd_pend_q;
    rd_addr_d = rd_addr_q;
    if (rd_done) begin
      rd_pend_d = 1'b0;
    end else if (bus.mem_read_req && !rd_pend_q) begin
      rd_pend_d = 1'b1;
      rd_addr_d = {bus.cpu_adr[AW:3], 2'b00};
    end
  end

  // Issue FSM: writes drain before any read; request fields load on entry only.
  always_comb begin
    state_d        = state_q;
    sd_req_d       = sd_req_q;
    sd_we_d        = sd_we_q;
    sd_addr_d      = sd_addr_q;
    sd_be_d        = sd_be_q;
    sd_dout_d      = sd_dout_q;
    mem_dat_r_d    = mem_dat_r_q;
    mem_read_ack_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          state_d   = WR;
          sd_req_d  = 1'b1;
          sd_we_d   = 1'b1;
          sd_addr_d = head_adr;
          sd_be_d   = head_bs;
          sd_dout_d = head_dat;
        end else if (rd_pend_q) begin
          state_d   = RD;
          sd_req_d  = 1'b1;
          sd_we_d   = 1'b0;
          sd_addr_d = rd_addr_q;
        end
      end
      WR: begin
        if (bus.sd_ack) begin
          state_d  = IDLE;
          sd_req_d = 1'b0;
        end
      end
      RD: begin
        if (bus.sd_ack) begin
          state_d        = IDLE;
          sd_req_d       = 1'b0;
          mem_dat_r_d    = bus.sd_din;
          mem_read_ack_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      captured_q     <= 1'b0;
      wb_ack_q       <= 1'b0;
      rd_pend_q      <= 1'b0;
      rd_addr_q      <= '0;
      sd_req_q       <= 1'b0;
      sd_we_q        <= 1'b0;
      sd_addr_q      <= '0;
      sd_be_q        <= '0;
      sd_dout_q      <= '0;
      mem_dat_r_q    <= '0;
      mem_read_ack_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      captured_q     <= captured_d;
      wb_ack_q       <= wb_ack_d;
      rd_pend_q      <= rd_pend_d;
      rd_addr_q      <= rd_addr_d;
      sd_req_q       <= sd_req_d;
      sd_we_q        <= sd_we_d;
      sd_addr_q      <= sd_addr_d;
      sd_be_q        <= sd_be_d;
      sd_dout_q      <= sd_dout_d;
      mem_dat_r_q    <= mem_dat_r_d;
      mem_read_ack_q <= mem_read_ack_d;
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {bus.cpu_adr, bus.cpu_bs, bus.cpu_dat_w};
  end

  assign bus.wb_ack       = wb_ack_q;
  assign bus.mem_dat_r    = mem_dat_r_q;
  assign bus.mem_read_ack = mem_read_ack_q;
  assign bus.sd_req       = sd_req_q;
  assign bus.sd_we        = sd_we_q;
  assign bus.sd_addr      = sd_addr_q;
  assign bus.sd_be        = sd_be_q;
  assign bus.sd_dout      = sd_dout_q;

endmodule
